// File: rtl/kf8255_handshake_ctrl.sv
// Strobed-mode handshake sequencer for one KF8255 group port.
// Synchronises STB_n/ACK_n and maintains IBF, OBF_n, INTE and INTR for modes 1 and 2.
module kf8255_handshake_ctrl #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] mode_select_reg,
   input  logic       port_io_reg,
   input  logic       update_mode,
   input  logic       read_port,
   input  logic       write_port,
   input  logic       inte_write,
   input  logic       inte_sel,
   input  logic       inte_value,
   input  logic       stb_n,
   input  logic       ack_n,
   output logic       strobe,
   output logic       hiz,
   output logic       ibf,
   output logic       obf_n,
   output logic       intr,
   output logic [4:0] status
);

   logic [SYNC_STAGES-1:0] stbSync_q;
   logic [SYNC_STAGES-1:0] ackSync_q;
   logic                   stbPrev_q;
   logic                   ackPrev_q;

   logic ibf_q,     ibf_d;
   logic obfN_q,    obfN_d;
   logic intrIn_q,  intrIn_d;
   logic intrOut_q, intrOut_d;
   logic inteIn_q,  inteIn_d;
   logic inteOut_q, inteOut_d;
   logic intr_q,    intr_d;
   logic strobe_q,  strobe_d;
   logic hiz_q,     hiz_d;

   logic modeZero;
   logic modeOne;
   logic modeTwo;
   logic inEnable;
   logic outEnable;
   logic stbSynced;
   logic ackSynced;
   logic stbFall;
   logic stbRise;
   logic ackFall;
   logic ackRise;

   // Pin synchronisers idle high so reset never looks like a strobe or acknowledge edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         stbSync_q <= '1;
         ackSync_q <= '1;
         stbPrev_q <= 1'b1;
         ackPrev_q <= 1'b1;
      end else begin
         stbSync_q <= {stbSync_q[SYNC_STAGES-2:0], stb_n};
         ackSync_q <= {ackSync_q[SYNC_STAGES-2:0], ack_n};
         stbPrev_q <= stbSync_q[SYNC_STAGES-1];
         ackPrev_q <= ackSync_q[SYNC_STAGES-1];
      end
   end

   assign stbSynced = stbSync_q[SYNC_STAGES-1];
   assign ackSynced = ackSync_q[SYNC_STAGES-1];
   assign stbFall   = stbPrev_q & ~stbSynced;
   assign stbRise   = ~stbPrev_q & stbSynced;
   assign ackFall   = ackPrev_q & ~ackSynced;
   assign ackRise   = ~ackPrev_q & ackSynced;

   assign modeZero  = (mode_select_reg == 2'b00);
   assign modeOne   = (mode_select_reg == 2'b01);
   assign modeTwo   = mode_select_reg[1];
   assign inEnable  = (modeOne & port_io_reg) | modeTwo;
   assign outEnable = (modeOne & ~port_io_reg) | modeTwo;

   // Flag next-state: within each side the set event wins, then update_mode and mode 0 override everything.
   always_comb begin
      ibf_d     = ibf_q;
      obfN_d    = obfN_q;
      intrIn_d  = intrIn_q;
      intrOut_d = intrOut_q;
      inteIn_d  = inteIn_q;
      inteOut_d = inteOut_q;
      intr_d    = (inEnable & intrIn_q) | (outEnable & intrOut_q);
      strobe_d  = inEnable & ~stbSynced;
      hiz_d     = ~(modeTwo & ~ackSynced);

      if (inte_write) begin
         if (inte_sel) begin
            inteOut_d = inte_value;
         end else begin
            inteIn_d = inte_value;
         end
      end

      if (inEnable) begin
         if (read_port) begin
            ibf_d    = 1'b0;
            intrIn_d = 1'b0;
         end
         if (stbFall) begin
            ibf_d = 1'b1;
         end
         if (stbRise && ibf_q && inteIn_q) begin
            intrIn_d = 1'b1;
         end
      end

      if (outEnable) begin
         if (ackFall) begin
            obfN_d = 1'b1;
         end
         if (write_port) begin
            obfN_d    = 1'b0;
            intrOut_d = 1'b0;
         end
         if (ackRise && obfN_q && inteOut_q) begin
            intrOut_d = 1'b1;
         end
      end

      if (update_mode) begin
         ibf_d     = 1'b0;
         obfN_d    = 1'b1;
         intrIn_d  = 1'b0;
         intrOut_d = 1'b0;
         inteIn_d  = 1'b0;
         inteOut_d = 1'b0;
         intr_d    = 1'b0;
      end

      if (modeZero) begin
         ibf_d     = 1'b0;
         obfN_d    = 1'b1;
         intrIn_d  = 1'b0;
         intrOut_d = 1'b0;
         inteIn_d  = 1'b0;
         inteOut_d = 1'b0;
         intr_d    = 1'b0;
         strobe_d  = 1'b0;
         hiz_d     = 1'b1;
      end
   end

   // Flag and datapath-control registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         ibf_q     <= 1'b0;
         obfN_q    <= 1'b1;
         intrIn_q  <= 1'b0;
         intrOut_q <= 1'b0;
         inteIn_q  <= 1'b0;
         inteOut_q <= 1'b0;
         intr_q    <= 1'b0;
         strobe_q  <= 1'b0;
         hiz_q     <= 1'b1;
      end else begin
         ibf_q     <= ibf_d;
         obfN_q    <= obfN_d;
         intrIn_q  <= intrIn_d;
         intrOut_q <= intrOut_d;
         inteIn_q  <= inteIn_d;
         inteOut_q <= inteOut_d;
         intr_q    <= intr_d;
         strobe_q  <= strobe_d;
         hiz_q     <= hiz_d;
      end
   end

   assign strobe = strobe_q;
   assign hiz    = hiz_q;
   assign ibf    = ibf_q;
   assign obf_n  = obfN_q;
   assign intr   = intr_q;
   assign status = {intr_q, inteIn_q, inteOut_q, ibf_q, ~obfN_q};

endmodule

// File: tb/tb_kf8255_handshake_ctrl.sv
// Directed bench for kf8255_handshake_ctrl: reset, mode 1 in/out, mode 2, collisions, mode 0.
// Expected values are hand-derived for SYNC_STAGES=2 (pin edge to flag = 3 clocks).
module tb_kf8255_handshake_ctrl;

   logic       clock = 1'b0;
   logic       reset;
   logic [1:0] mode_select_reg;
   logic       port_io_reg;
   logic       update_mode;
   logic       read_port;
   logic       write_port;
   logic       inte_write;
   logic       inte_sel;
   logic       inte_value;
   logic       stb_n;
   logic       ack_n;
   logic       strobe;
   logic       hiz;
   logic       ibf;
   logic       obf_n;
   logic       intr;
   logic [4:0] status;

   int total = 0;
   int bad   = 0;

   kf8255_handshake_ctrl #(.SYNC_STAGES(2)) dut (
      .clock           (clock),
      .reset           (reset),
      .mode_select_reg (mode_select_reg),
      .port_io_reg     (port_io_reg),
      .update_mode     (update_mode),
      .read_port       (read_port),
      .write_port      (write_port),
      .inte_write      (inte_write),
      .inte_sel        (inte_sel),
      .inte_value      (inte_value),
      .stb_n           (stb_n),
      .ack_n           (ack_n),
      .strobe          (strobe),
      .hiz             (hiz),
      .ibf             (ibf),
      .obf_n           (obf_n),
      .intr            (intr),
      .status          (status)
   );

   // Free-running 10-unit clock.
   always #5 clock = ~clock;

   // Advance n clock edges and settle 1 unit past the last one.
   task automatic applyStimulus(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // One comparison: counts it and reports any disagreement.
   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Directed sequence; each step is relative to the edge just passed.
   initial begin
      logic [7:0] hizExp;

      reset = 1'b1; mode_select_reg = 2'b00; port_io_reg = 1'b0;
      update_mode = 1'b0; read_port = 1'b0; write_port = 1'b0;
      inte_write = 1'b0; inte_sel = 1'b0; inte_value = 1'b0;
      stb_n = 1'b0; ack_n = 1'b1;
      applyStimulus(2);
      checkOutput("rstStatus", 8'(status), 8'h00);
      checkOutput("rstObfN",   8'(obf_n),  8'h01);
      checkOutput("rstStrobe", 8'(strobe), 8'h00);
      checkOutput("rstHiz",    8'(hiz),    8'h01);
      reset = 1'b0; stb_n = 1'b1;
      applyStimulus(4);

      $display("[TB] mode 1 input");
      mode_select_reg = 2'b01; port_io_reg = 1'b1; update_mode = 1'b1;
      applyStimulus(1);
      update_mode = 1'b0; inte_write = 1'b1; inte_sel = 1'b0; inte_value = 1'b1;
      applyStimulus(1);
      inte_write = 1'b0;
      checkOutput("m1inInte", 8'(status), 8'b01000);
      stb_n = 1'b0;
      applyStimulus(1);
      stb_n = 1'b1;
      checkOutput("m1inIbfT1", 8'(ibf), 8'h00);
      applyStimulus(1);
      checkOutput("m1inIbfT2", 8'(ibf), 8'h00);
      checkOutput("m1inStbT2", 8'(strobe), 8'h00);
      applyStimulus(1);
      checkOutput("m1inIbfT3", 8'(ibf), 8'h01);
      checkOutput("m1inStbT3", 8'(strobe), 8'h01);
      checkOutput("m1inIntrT3", 8'(intr), 8'h00);
      applyStimulus(1);
      checkOutput("m1inStbT4", 8'(strobe), 8'h00);
      checkOutput("m1inIntrT4", 8'(intr), 8'h00);
      applyStimulus(1);
      checkOutput("m1inIntrT5", 8'(intr), 8'h01);
      checkOutput("m1inStatT5", 8'(status), 8'b11010);
      read_port = 1'b1;
      applyStimulus(1);
      read_port = 1'b0;
      checkOutput("m1inRdIbf", 8'(ibf), 8'h00);
      applyStimulus(1);
      checkOutput("m1inRdIntr", 8'(intr), 8'h00);
      checkOutput("m1inRdStat", 8'(status), 8'b01000);

      $display("[TB] mode 1 output");
      port_io_reg = 1'b0; update_mode = 1'b1;
      applyStimulus(1);
      update_mode = 1'b0; inte_write = 1'b1; inte_sel = 1'b1; inte_value = 1'b1;
      applyStimulus(1);
      inte_write = 1'b0;
      checkOutput("m1outInte", 8'(status), 8'b00100);
      write_port = 1'b1;
      applyStimulus(1);
      write_port = 1'b0;
      checkOutput("m1outWrObf", 8'(obf_n), 8'h00);
      checkOutput("m1outWrStat", 8'(status), 8'b00101);
      ack_n = 1'b0;
      applyStimulus(2);
      checkOutput("m1outObfA2", 8'(obf_n), 8'h00);
      applyStimulus(1);
      checkOutput("m1outObfA3", 8'(obf_n), 8'h01);
      checkOutput("m1outHizA3", 8'(hiz), 8'h01);
      ack_n = 1'b1;
      applyStimulus(3);
      checkOutput("m1outIntrA6", 8'(intr), 8'h00);
      applyStimulus(1);
      checkOutput("m1outIntrA7", 8'(intr), 8'h01);
      checkOutput("m1outStatA7", 8'(status), 8'b10100);
      write_port = 1'b1;
      applyStimulus(1);
      write_port = 1'b0;
      checkOutput("m1outWr2Obf", 8'(obf_n), 8'h00);
      applyStimulus(1);
      checkOutput("m1outWr2Intr", 8'(intr), 8'h00);
      checkOutput("m1outWr2Stat", 8'(status), 8'b00101);

      $display("[TB] mode 2 bus");
      mode_select_reg = 2'b10; update_mode = 1'b1;
      applyStimulus(1);
      update_mode = 1'b0;
      hizExp = 8'b1000_0110;
      ack_n = 1'b0; stb_n = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         applyStimulus(1);
         checkOutput($sformatf("m2hiz%0d", i), 8'(hiz), 8'(hizExp[i]));
         if (i == 3) begin
            checkOutput("m2ibf", 8'(ibf), 8'h01);
            checkOutput("m2strobe", 8'(strobe), 8'h01);
         end
         if (i == 1) stb_n = 1'b1;
         if (i == 4) ack_n = 1'b1;
      end
      checkOutput("m2intr", 8'(intr), 8'h00);
      checkOutput("m2obfN", 8'(obf_n), 8'h01);
      read_port = 1'b1;
      applyStimulus(1);
      read_port = 1'b0;
      checkOutput("m2rdIbf", 8'(ibf), 8'h00);

      $display("[TB] collisions");
      stb_n = 1'b0;
      applyStimulus(1);
      stb_n = 1'b1;
      applyStimulus(1);
      read_port = 1'b1;
      applyStimulus(1);
      read_port = 1'b0;
      checkOutput("rdCollide", 8'(ibf), 8'h01);
      applyStimulus(3);
      read_port = 1'b1;
      applyStimulus(1);
      read_port = 1'b0;
      checkOutput("rdClear", 8'(ibf), 8'h00);

      ack_n = 1'b0;
      applyStimulus(2);
      write_port = 1'b1;
      applyStimulus(1);
      write_port = 1'b0;
      checkOutput("wrCollide", 8'(obf_n), 8'h00);
      ack_n = 1'b1;
      applyStimulus(4);
      checkOutput("wrCollideObf", 8'(obf_n), 8'h00);
      checkOutput("wrCollideIntr", 8'(intr), 8'h00);

      inte_write = 1'b1; inte_sel = 1'b0; inte_value = 1'b1;
      applyStimulus(1);
      inte_write = 1'b0;
      checkOutput("updPreStat", 8'(status), 8'b01001);
      stb_n = 1'b0;
      applyStimulus(1);
      stb_n = 1'b1;
      applyStimulus(1);
      update_mode = 1'b1;
      applyStimulus(1);
      update_mode = 1'b0;
      checkOutput("updCollide", 8'(status), 8'b00000);
      checkOutput("updCollideIbf", 8'(ibf), 8'h00);
      applyStimulus(2);
      checkOutput("updCollideIntr", 8'(intr), 8'h00);

      $display("[TB] mode 0 isolation");
      mode_select_reg = 2'b00; update_mode = 1'b1;
      applyStimulus(1);
      update_mode = 1'b0;
      stb_n = 1'b0; ack_n = 1'b0; write_port = 1'b1;
      inte_write = 1'b1; inte_sel = 1'b1; inte_value = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         applyStimulus(1);
         if (i == 1) begin
            write_port = 1'b0; inte_write = 1'b0;
         end
         if (i == 3) begin
            stb_n = 1'b1; ack_n = 1'b1;
         end
         checkOutput($sformatf("m0stat%0d", i), 8'(status), 8'h00);
         checkOutput($sformatf("m0obfN%0d", i), 8'(obf_n), 8'h01);
         checkOutput($sformatf("m0strobe%0d", i), 8'(strobe), 8'h00);
         checkOutput($sformatf("m0hiz%0d", i), 8'(hiz), 8'h01);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/kf8255_handshake_ctrl.md
Name: kf8255_handshake_ctrl

Overview:
- Strobed-mode sequencer for one KF8255 group port (mode 1 input/output, mode 2 bidirectional).
- Synchronises the STB_n/ACK_n port-C pins and drives the port datapath's `strobe` and `hiz` inputs.
- Maintains the IBF, OBF_n, INTE and INTR flags and exposes them to the port-C read mux and the status path.
- Sits beside the group port datapath; its control inputs come from the same mode and register decode that feeds that datapath.

Parameters:
SYNC_STAGES, 2, flip-flop stages on stb_n/ack_n pin inputs (legal: 2..4)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
mode_select_reg  input  2  group mode: 00 mode0, 01 mode1, 1x mode2
port_io_reg  input  1  mode-1 direction: 1 input, 0 output
update_mode  input  1  1-cycle pulse: control word written
read_port  input  1  1-cycle pulse: CPU read of this port completed
write_port  input  1  1-cycle pulse: CPU write of this port
inte_write  input  1  1-cycle pulse: port-C bit set/reset hits an INTE bit
inte_sel  input  1  0 selects INTE_IN, 1 selects INTE_OUT
inte_value  input  1  value written to selected INTE
stb_n  input  1  async strobe pin (active low)
ack_n  input  1  async acknowledge pin (active low)
strobe  output  1  to port datapath: 1 = latch port_in this cycle
hiz  output  1  to port datapath (mode 2): 0 = drive bus
ibf  output  1  input buffer full
obf_n  output  1  output buffer full, active low
intr  output  1  interrupt request
status  output  5  {intr, inte_in, inte_out, ibf, ~obf_n}

Behaviour:
Reset (reset=1 at a clock edge):
- All sync flops = 1.
- ibf=0, obf_n=1, intr_in=intr_out=0, inte_in=inte_out=0, strobe=0, hiz=1, status=5'b00000.
- Reset mid-handshake aborts immediately; no pending edge survives.

Pin synchronisation and timing:
- stb_s/ack_s = last stage of the SYNC_STAGES chain; prev flops hold the previous cycle's value.
- fall = prev & ~cur; rise = ~prev & cur.
- Pin edge to flag change = SYNC_STAGES+1 clocks.

Side enables:
- IN side enabled: mode1 & port_io_reg=1, or mode2.
- OUT side enabled: mode1 & port_io_reg=0, or mode2.
- Mode 0: all flags are held at their reset values, strobe=0, hiz=1; pins are ignored.

Input side (registered outputs):
- strobe = IN enabled & ~stb_s, so the datapath captures the value present at STB_n rising.
- ibf: set on stb fall; cleared on read_port. Simultaneous set and clear: set wins.
- intr_in: set on stb rise when ibf=1 & inte_in=1; cleared on read_port. Simultaneous: set wins.

Output side:
- obf_n: driven to 0 on write_port; driven to 1 on ack fall. Simultaneous write_port and ack fall: obf_n=0 (new data pending).
- intr_out: set on ack rise when obf_n=1 & inte_out=1; cleared on write_port. Simultaneous: set wins.
- hiz = 0 only in mode 2 while ack_s=0; 1 otherwise.

Combination and INTE:
- intr = (IN enabled & intr_in) | (OUT enabled & intr_out), registered (one cycle after the flag).
- inte_write updates the selected INTE on the next edge.
- Clearing an INTE does not clear an already-set intr flag; setting an INTE does not raise intr retroactively.

update_mode and direction change:
- update_mode clears ibf, intr_in, intr_out and both INTE; sets obf_n=1. It has priority over every other event in that cycle.
- A port_io_reg change without update_mode does not alter the flags.

Test Plan:
- Reset: assert reset with stb_n=0 -> next cycle status=00000, obf_n=1, strobe=0, hiz=1.
- Mode 1 input: mode=01, io=1, inte_in set, drive stb_n low at t0 -> ibf=1 at t0+3, strobe high while synced low. Release stb_n -> intr=1 by t0+5. read_port pulse -> ibf=0, intr=0 next cycle.
- Mode 1 output: mode=01, io=0, inte_out=1; write_port -> obf_n=0. ack_n low -> obf_n=1 after 3 clocks. ack_n high -> intr=1. A further write_port -> intr=0, obf_n=0.
- Mode 2 bus: mode=10, ack_n low for 4 cycles -> hiz=0 for exactly those 4 synced cycles. Concurrent STB handshake -> ibf behaves as in the mode 1 input case.
- Collisions:
  - read_port in the same cycle as stb fall -> ibf stays 1.
  - write_port in the same cycle as ack fall -> obf_n=0.
  - update_mode in the same cycle as stb fall -> ibf=0, inte cleared.
- Mode 0 isolation: mode=00, toggle stb_n/ack_n and pulse write_port -> every output stays at its reset value.
